savg_stream: RTL
================

# savg_stream

Streaming signed averager. Accepts one signed sample per handshake and outputs the arithmetic mean of 2^LOG2N samples. Two modes: block averaging (one result per 2^LOG2N samples) or sliding-window averaging (one result per sample once the window is full). It is the sequential, parametrised successor to the fixed eight-input combinational averaging datapath, and sits between a sample source and a registered consumer using valid/ready on both sides.

## Interface
- DATAWIDTH, 16, sample and result width (signed)
- LOG2N, 3, log2 of the window length N; N = 2^LOG2N, 1 ≤ LOG2N ≤ 8
- ACCWIDTH, DATAWIDTH+LOG2N, accumulator width (derived, not overridden)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mode  in  1  0 = block average, 1 = sliding-window average
- in_valid  in  1  sample present
- in_data  in  DATAWIDTH  signed sample
- in_ready  out  1  block can accept a sample this cycle
- out_valid  out  1  avg holds an unconsumed result
- out_ready  in  1  consumer takes the result
- avg  out  DATAWIDTH  signed mean, registered

## Operation
- Accept: in_valid && in_ready at a rising edge.
- in_ready = rst && !mode_chg && (!out_valid || out_ready). This gives a one-deep output register with pass-through when the consumer drains in the same cycle.
- mode_q register tracks mode. mode_chg = (mode != mode_q).
- When mode_chg is high for a cycle, the next edge clears acc, cnt, fill and wr_ptr, and loads mode_q. No sample is accepted in that cycle. A pending avg/out_valid is kept.
- Block mode (mode_q = 0):
  - Each accept: acc += sext(in_data) and cnt++.
  - On the accept where cnt = N-1: avg <= (acc + sext(in_data)) >>> LOG2N, truncated to DATAWIDTH. Then out_valid <= 1, acc <= 0, cnt <= 0.
- Sliding mode (mode_q = 1):
  - Circular buffer buf[0..N-1] of DATAWIDTH, write pointer wr_ptr (LOG2N bits, wraps N-1→0), fill counter 0..N saturating.
  - old = (fill == N) ? buf[wr_ptr] : 0.
  - Each accept: acc <= acc + sext(in_data) − sext(old), buf[wr_ptr] <= in_data, wr_ptr++, fill saturating ++.
  - If (fill == N-1 or fill == N): avg <= (acc + sext(in_data) − sext(old)) >>> LOG2N, and out_valid <= 1.
- Arithmetic:
  - Full signed arithmetic in ACCWIDTH bits; never overflows.
  - Division is an arithmetic right shift, so results floor toward −∞.
  - The mean of in-range samples always fits DATAWIDTH, so truncation is lossless.
- Output: out_valid && out_ready clears out_valid unless a new result loads on the same edge, in which case out_valid stays 1 with the new avg.
- avg holds its value while out_valid && !out_ready. It also holds its last value after being consumed.

## Timing
- Reset (rst = 0, asynchronous): avg = 0, out_valid = 0, in_ready = 0, acc = 0, cnt = 0, fill = 0, wr_ptr = 0, mode_q = 0. Buffer contents are don't-care because fill gates them.
- First accept possible on the first edge after rst deasserts, provided mode = 0. If mode = 1 at that point, the first cycle is the clear cycle.
- Latency: result is visible (out_valid = 1) the cycle after the completing accept edge.
- Throughput is 1 sample/cycle with out_ready held high:
  - Block mode: one result per N accepts.
  - Sliding mode: one result per accept after the first N-1.
- Backpressure: while out_valid && !out_ready, in_ready = 0 and no state advances.
- Reset mid-window discards the partial sum and any pending output.

## Test plan
- Block, LOG2N = 3, out_ready = 1, samples 1..8 → single result avg = 4 (36>>>3), out_valid high exactly one cycle. Samples 9..16 → avg = 12.
- Block floor/extremes:
  - −1 then seven 0s → avg = −1.
  - Eight × 32767 → 32767.
  - Eight × −32768 → −32768.
- Sliding, LOG2N = 3, samples 1..10 → no output for the first 7. Then avg = 4, 5, 6 on accepts 8, 9, 10. wr_ptr wraps after accept 8.
- Backpressure: block mode, out_ready = 0 after the first result. in_ready stays 0 and avg holds 4 for 5 cycles. Raise out_ready, then feed eight 2s → avg = 2.
- Mode switch mid-stream: 3 samples in block mode, toggle mode → one cycle with in_ready = 0. Then eight 5s → sliding outputs begin at the 8th with avg = 5. Earlier samples must not contaminate the result.
- Reset mid-operation: 5 samples of 100, pulse rst low asynchronously (between edges) → avg = 0 and out_valid = 0 immediately. Then eight 7s → avg = 7.

Source files
------------

// File: rtl/savg_stream.sv
// Streaming signed averager over 2^LOG2N samples, block or sliding-window mode,
// valid/ready on both sides with a one-deep registered result.
module savg_stream #(
  parameter int DATAWIDTH = 16,
  parameter int LOG2N     = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mode,
  input  logic                        in_valid,
  input  logic signed [DATAWIDTH-1:0] in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [DATAWIDTH-1:0] avg
);

  localparam int ACCWIDTH = DATAWIDTH + LOG2N;
  localparam int N        = 1 << LOG2N;

  localparam logic [LOG2N-1:0] CNT_LAST  = LOG2N'(N - 1);
  localparam logic [LOG2N:0]   FILL_FULL = (LOG2N + 1)'(N);
  localparam logic [LOG2N:0]   FILL_LAST = (LOG2N + 1)'(N - 1);

  logic                        r_mode_q;
  logic signed [ACCWIDTH-1:0]  r_acc;
  logic [LOG2N-1:0]            r_cnt;
  logic [LOG2N:0]              r_fill;
  logic [LOG2N-1:0]            r_wr_ptr;
  logic signed [DATAWIDTH-1:0] r_buf [N];
  logic signed [DATAWIDTH-1:0] r_avg;
  logic                        r_out_valid;

  logic                        w_mode_chg;
  logic                        w_accept;
  logic                        w_load;
  logic signed [DATAWIDTH-1:0] w_old;
  logic signed [ACCWIDTH-1:0]  w_sum_blk;
  logic signed [ACCWIDTH-1:0]  w_sum_sld;

  // Floor division by N; the mean of in-range samples always fits DATAWIDTH.
  function automatic logic signed [DATAWIDTH-1:0] mean_of(input logic signed [ACCWIDTH-1:0] s);
    logic signed [ACCWIDTH-1:0] q;
    q = s >>> LOG2N;
    return q[DATAWIDTH-1:0];
  endfunction

  assign w_mode_chg = (mode != r_mode_q);
  assign in_ready   = rst && !w_mode_chg && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;

  // The sample leaving the window only counts once the buffer is full.
  assign w_old     = (r_fill == FILL_FULL) ? r_buf[r_wr_ptr] : '0;
  assign w_sum_blk = r_acc + ACCWIDTH'(in_data);
  assign w_sum_sld = r_acc + ACCWIDTH'(in_data) - ACCWIDTH'(w_old);

  assign w_load = w_accept && (r_mode_q ? (r_fill >= FILL_LAST) : (r_cnt == CNT_LAST));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode_q <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_fill   <= '0;
      r_wr_ptr <= '0;
    end else if (w_mode_chg) begin
      r_mode_q <= mode;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_fill   <= '0;
      r_wr_ptr <= '0;
    end else if (w_accept) begin
      if (!r_mode_q) begin
        if (r_cnt == CNT_LAST) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc <= w_sum_blk;
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_acc    <= w_sum_sld;
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_fill != FILL_FULL) r_fill <= r_fill + 1'b1;
      end
    end
  end

  // Window storage needs no reset: fill decides whether an entry is live.
  always_ff @(posedge clk) begin
    if (w_accept && r_mode_q) r_buf[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_avg       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_avg       <= r_mode_q ? mean_of(w_sum_sld) : mean_of(w_sum_blk);
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign avg       = r_avg;
  assign out_valid = r_out_valid;

endmodule
